// File: rtl/delivery_controller.sv
// Delivery sequencer for one cricket ball: bowl, flight, hit window, result hold.
// Grades the swing detector's strike pulse and keeps the innings score, wickets and balls.
module delivery_controller #(
  parameter int CNT_W         = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int WINDOW_CYCLES = 12,
  parameter int GOOD_LO       = 4,
  parameter int GOOD_HI       = 7,
  parameter int RESULT_CYCLES = 8,
  parameter int TOTAL_BALLS   = 6,
  parameter int MAX_WICKETS   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bowl,
  input  logic       strike,
  output logic       in_flight,
  output logic       window_open,
  output logic       result_valid,
  output logic [2:0] last_runs,
  output logic       last_wicket,
  output logic [8:0] score,
  output logic [3:0] wickets,
  output logic [3:0] balls,
  output logic       innings_done
);

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GOOD_LO_C   = CNT_W'(GOOD_LO);
  localparam logic [CNT_W-1:0] GOOD_HI_C   = CNT_W'(GOOD_HI);
  localparam logic [3:0]       BALLS_END   = 4'(TOTAL_BALLS);
  localparam logic [3:0]       WKTS_END    = 4'(MAX_WICKETS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BOWL   = 3'd1,
    ST_WINDOW = 3'd2,
    ST_RESULT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       last_runs_q;
  logic             last_wicket_q;
  logic [8:0]       score_q;
  logic [3:0]       wickets_q;
  logic [3:0]       balls_q;

  // Outcome of the ball being closed out this cycle; only meaningful when load is high.
  logic             load;
  logic [2:0]       new_runs;
  logic             new_wicket;
  logic [9:0]       score_sum;
  logic             innings_over;

  assign innings_over = (balls_q == BALLS_END) || (wickets_q == WKTS_END);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    new_runs   = 3'd0;
    new_wicket = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bowl) begin
          state_d = ST_BOWL;
          cnt_d   = '0;
        end
      end
      ST_BOWL: begin
        if (strike) begin
          // Early swing: ball is over, no runs and no wicket.
          state_d = ST_RESULT;
          cnt_d   = '0;
          load    = 1'b1;
        end else if (cnt_q == TRAVEL_LAST) begin
          state_d = ST_WINDOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WINDOW: begin
        if (strike) begin
          state_d = ST_RESULT;
          cnt_d   = '0;
          load    = 1'b1;
          if (cnt_q < GOOD_LO_C)       new_runs = 3'd1;
          else if (cnt_q <= GOOD_HI_C) new_runs = 3'd6;
          else                         new_runs = 3'd2;
        end else if (cnt_q == WINDOW_LAST) begin
          state_d    = ST_RESULT;
          cnt_d      = '0;
          load       = 1'b1;
          new_wicket = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESULT: begin
        if (cnt_q == RESULT_LAST) begin
          state_d = innings_over ? ST_DONE : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign score_sum = {1'b0, score_q} + {7'd0, new_runs};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_runs_q   <= 3'd0;
      last_wicket_q <= 1'b0;
      score_q       <= 9'd0;
      wickets_q     <= 4'd0;
      balls_q       <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        last_runs_q   <= new_runs;
        last_wicket_q <= new_wicket;
        score_q       <= score_sum[9] ? 9'd511 : score_sum[8:0];
        wickets_q     <= wickets_q + {3'd0, new_wicket};
        balls_q       <= balls_q + 4'd1;
      end
    end
  end

  assign in_flight    = (state_q == ST_BOWL);
  assign window_open  = (state_q == ST_WINDOW);
  assign result_valid = (state_q == ST_RESULT) && (cnt_q == '0);
  assign innings_done = (state_q == ST_DONE);
  assign last_runs    = last_runs_q;
  assign last_wicket  = last_wicket_q;
  assign score        = score_q;
  assign wickets      = wickets_q;
  assign balls        = balls_q;

endmodule

// File: tb/tb_delivery_controller.sv
// Self-checking bench for delivery_controller: each ball is described by the cycle of its
// strike and the expected outcome is computed from the game rules in a small score model.
module tb_delivery_controller;

  logic       clock = 1'b0;
  logic       reset, bowl, strike;
  logic       in_flight, window_open, result_valid, last_wicket, innings_done;
  logic [2:0] last_runs;
  logic [8:0] score;
  logic [3:0] wickets, balls;

  int n_checks = 0;
  int n_fail   = 0;

  // Innings model
  int m_score, m_wk, m_balls, m_runs;
  bit m_last_wk, m_done;

  delivery_controller dut (
    .clock(clock), .reset(reset), .bowl(bowl), .strike(strike),
    .in_flight(in_flight), .window_open(window_open), .result_valid(result_valid),
    .last_runs(last_runs), .last_wicket(last_wicket), .score(score),
    .wickets(wickets), .balls(balls), .innings_done(innings_done)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    m_score = 0; m_wk = 0; m_balls = 0; m_runs = 0; m_last_wk = 0; m_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; strike = 1'b0; bowl = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  // One delivery. s = index of the cycle (counted from 0 after bowl is sampled) in which
  // strike is high; s<0 means no strike. Must be called at a negedge with the DUT in IDLE.
  task automatic deliver(input int s, input bit hold);
    int exp_t, runs, w;
    bit wk;
    if (s < 0 || s > 27) begin exp_t = 29; runs = 0; wk = 1; end
    else if (s < 16) begin exp_t = s + 2; runs = 0; wk = 0; end
    else begin
      w = s - 16; exp_t = s + 2; wk = 0;
      runs = (w < 4) ? 1 : ((w <= 7) ? 6 : 2);
    end
    bowl = 1'b1; strike = 1'b0;
    for (int t = 1; t <= exp_t + 8; t++) begin
      @(negedge clock);
      if (t == 1 && !hold) bowl = 1'b0;
      if (t < exp_t) begin
        n_checks++;
        if (in_flight !== (t <= 16) || window_open !== (t >= 17) || result_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL phase t=%0d: in_flight=%b window_open=%b result_valid=%b, required %b %b 0",
                   t, in_flight, window_open, result_valid, (t <= 16), (t >= 17));
        end
        strike = (t - 1 == s);
      end else if (t == exp_t) begin
        strike = 1'b0;
        m_runs = runs; m_last_wk = wk;
        m_score = (m_score + runs > 511) ? 511 : m_score + runs;
        m_wk += int'(wk); m_balls++;
        m_done = (m_balls == 6) || (m_wk == 2);
        n_checks++;
        if (result_valid !== 1'b1 || in_flight !== 1'b0 || window_open !== 1'b0) begin
          n_fail++;
          $display("FAIL result_timing t=%0d: result_valid=%b in_flight=%b window_open=%b, required 1 0 0",
                   t, result_valid, in_flight, window_open);
        end
        n_checks++;
        if (last_runs !== 3'(runs) || last_wicket !== wk || score !== 9'(m_score) ||
            wickets !== 4'(m_wk) || balls !== 4'(m_balls)) begin
          n_fail++;
          $display("FAIL result_values: runs=%0d wk=%b score=%0d wickets=%0d balls=%0d, required %0d %b %0d %0d %0d",
                   last_runs, last_wicket, score, wickets, balls, runs, wk, m_score, m_wk, m_balls);
        end
        $display("ball %0d: strike_cycle=%0d runs=%0d wicket=%b score=%0d wickets=%0d",
                 m_balls, s, last_runs, last_wicket, score, wickets);
      end else if (t < exp_t + 7) begin
        strike = 1'($urandom_range(0, 1));
        if (!hold) bowl = 1'($urandom_range(0, 1));
        n_checks++;
        if (result_valid !== 1'b0 || innings_done !== 1'b0) begin
          n_fail++;
          $display("FAIL result_hold t=%0d: result_valid=%b innings_done=%b, required 0 0",
                   t, result_valid, innings_done);
        end
      end else if (t == exp_t + 7) begin
        strike = 1'b0; bowl = hold;
      end else begin
        n_checks++;
        if (innings_done !== m_done || in_flight !== 1'b0 || window_open !== 1'b0 ||
            result_valid !== 1'b0 || score !== 9'(m_score) || balls !== 4'(m_balls)) begin
          n_fail++;
          $display("FAIL after_result: done=%b in_flight=%b win=%b rv=%b score=%0d balls=%0d, required %b 0 0 0 %0d %0d",
                   innings_done, in_flight, window_open, result_valid, score, balls,
                   m_done, m_score, m_balls);
        end
      end
    end
  endtask

  task automatic test_reset();
    bowl = 1'b1; strike = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (in_flight !== 0 || window_open !== 0 || result_valid !== 0 || innings_done !== 0 ||
        last_runs !== 0 || last_wicket !== 0 || score !== 0 || wickets !== 0 || balls !== 0) begin
      n_fail++;
      $display("FAIL reset_state: flt=%b win=%b rv=%b done=%b runs=%0d wk=%b score=%0d wkts=%0d balls=%0d, required all 0",
               in_flight, window_open, result_valid, innings_done, last_runs, last_wicket,
               score, wickets, balls);
    end
    reset = 1'b0; bowl = 1'b0; strike = 1'b0;
    model_clear();
  endtask

  task automatic test_perfect();
    do_reset();
    deliver(21, 1'b0);
  endtask

  task automatic test_window_edges();
    do_reset();
    deliver(16, 1'b0);
    deliver(27, 1'b0);
  endtask

  task automatic test_early();
    do_reset();
    deliver(2, 1'b0);
  endtask

  task automatic test_done_ignores();
    for (int i = 0; i < 40; i++) begin
      bowl = 1'($urandom_range(0, 1)); strike = 1'($urandom_range(0, 1));
      @(negedge clock);
      n_checks++;
      if (innings_done !== 1'b1 || in_flight !== 0 || window_open !== 0 || result_valid !== 0 ||
          score !== 9'(m_score) || wickets !== 4'(m_wk) || balls !== 4'(m_balls) ||
          last_runs !== 3'(m_runs) || last_wicket !== m_last_wk) begin
        n_fail++;
        $display("FAIL done_hold i=%0d: done=%b score=%0d wkts=%0d balls=%0d, required 1 %0d %0d %0d",
                 i, innings_done, score, wickets, balls, m_score, m_wk, m_balls);
      end
    end
    bowl = 1'b0; strike = 1'b0;
  endtask

  task automatic test_wickets();
    do_reset();
    deliver(-1, 1'b0);
    deliver(-1, 1'b0);
    test_done_ignores();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int b = 0; b < 6; b++) deliver(16 + $urandom_range(4, 7), 1'b1);
    bowl = 1'b0;
    test_done_ignores();
  endtask

  task automatic test_reset_mid();
    do_reset();
    deliver(20, 1'b0);
    deliver(20, 1'b0);
    bowl = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clock);
      if (t == 1) bowl = 1'b0;
    end
    reset = 1'b1; strike = 1'b1;
    @(negedge clock);
    n_checks++;
    if (in_flight !== 0 || window_open !== 0 || result_valid !== 0 || innings_done !== 0 ||
        last_runs !== 0 || last_wicket !== 0 || score !== 0 || wickets !== 0 || balls !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: flt=%b win=%b rv=%b runs=%0d score=%0d balls=%0d, required all 0",
               in_flight, window_open, result_valid, last_runs, score, balls);
    end
    reset = 1'b0; strike = 1'b0;
    model_clear();
    deliver(21, 1'b0);
  endtask

  task automatic test_random();
    int s;
    do_reset();
    for (int i = 0; i < 8 && !m_done; i++) begin
      s = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 27));
      deliver(s, 1'($urandom_range(0, 1)));
      bowl = 1'b0;
    end
    n_checks++;
    if (m_done !== 1'b1 || innings_done !== 1'b1) begin
      n_fail++;
      $display("FAIL random_innings_end: innings_done=%b model_done=%b, required 1 1",
               innings_done, m_done);
    end
  endtask

  initial begin
    reset = 1'b1; bowl = 1'b0; strike = 1'b0;
    model_clear();
    @(negedge clock);
    test_reset();
    test_perfect();
    test_window_edges();
    test_early();
    test_wickets();
    test_back_to_back();
    test_reset_mid();
    repeat (3) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delivery_controller.md
Name: delivery_controller

Overview:
- Sequences one delivery ("ball") of the cricket game: bowl request, ball flight, hit window, result hold.
- Consumes the single-cycle `strike` pulse from the swing detector and grades its timing into runs or a wicket.
- Keeps the innings score, wicket count and ball count, and flags end of innings.
- Sits between the swing detector and the score/HEX display and animation logic.

Parameters:
- CNT_W, 8: width of the internal phase counter; must hold max(TRAVEL_CYCLES, WINDOW_CYCLES, RESULT_CYCLES).
- TRAVEL_CYCLES, 16: cycles the ball is in flight before the hit window opens.
- WINDOW_CYCLES, 12: length of the hit window in cycles.
- GOOD_LO, 4: first window offset that counts as a perfect hit.
- GOOD_HI, 7: last window offset that counts as a perfect hit.
- RESULT_CYCLES, 8: cycles the result is held before the next ball.
- TOTAL_BALLS, 6: balls per innings.
- MAX_WICKETS, 2: wickets that end the innings.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- bowl  in  1  level request to start a delivery, sampled only in IDLE
- strike  in  1  one-cycle hit pulse from the swing detector
- in_flight  out  1  high while in BOWL
- window_open  out  1  high while in WINDOW
- result_valid  out  1  one-cycle pulse on the first RESULT cycle
- last_runs  out  3  runs of the most recent ball (0, 1, 2 or 6)
- last_wicket  out  1  most recent ball was a wicket
- score  out  9  innings runs, saturating at 511
- wickets  out  4  wickets fallen
- balls  out  4  balls bowled
- innings_done  out  1  high in DONE

Behaviour:
- Reset:
  - State goes to IDLE.
  - Counter, score, wickets, balls, last_runs and last_wicket are cleared to 0.
  - All 1-bit outputs are 0.
  - Reset has priority in every state, including mid-delivery; a delivery in progress is discarded with no score change.
- States: IDLE, BOWL, WINDOW, RESULT, DONE. All state transitions are registered; in_flight, window_open and innings_done are decoded from state.
- IDLE:
  - bowl=1 at a clock edge → BOWL next cycle, counter=0.
  - strike is ignored.
- BOWL:
  - The counter runs 0..TRAVEL_CYCLES-1. At count TRAVEL_CYCLES-1 with no strike → WINDOW, counter=0.
  - strike=1 in any BOWL cycle is an early swing → RESULT with runs=0, no wicket.
- WINDOW:
  - The counter holds the offset w = 0..WINDOW_CYCLES-1.
  - strike=1 at offset w → RESULT, graded as follows:
    - w<GOOD_LO → 1 run
    - GOOD_LO≤w≤GOOD_HI → 6 runs
    - w>GOOD_HI → 2 runs
  - No strike by w=WINDOW_CYCLES-1 → RESULT with a wicket and runs=0.
  - strike on the last window cycle wins over the timeout and is graded (2 runs with defaults).
- Update on the edge entering RESULT:
  - last_runs and last_wicket are loaded.
  - score += runs, saturating at 511.
  - wickets increments if a wicket fell.
  - balls increments.
  - Updated values are visible in the same cycle as result_valid.
- RESULT:
  - Lasts exactly RESULT_CYCLES cycles; strike and bowl are ignored.
  - Then → DONE if balls==TOTAL_BALLS or wickets==MAX_WICKETS, else → IDLE.
- DONE:
  - Absorbing until reset; all inputs are ignored; counters hold.
- Holding bowl high: back-to-back deliveries proceed, with IDLE lasting exactly one cycle between them.
- Latency: bowl edge to window_open = TRAVEL_CYCLES+1 cycles; strike edge to result_valid = 1 cycle.
- Only one strike is scored per delivery.

Test Plan:
- Reset, pulse bowl at cycle 0:
  - in_flight high for cycles 1–16; window_open high from cycle 17.
  - Strike at window offset 5 → result_valid at the next cycle, last_runs=6, score=6, balls=1.
- Strike at window offsets 0 and 11 on two balls → last_runs=1 then 2; score=3, wickets=0.
- Strike during BOWL at cycle 3 → last_runs=0, last_wicket=0, balls=1, window_open never asserted.
- No strike over two deliveries:
  - Each → last_wicket=1, result_valid exactly 12 cycles after window_open rises.
  - After the 2nd: wickets=2, innings_done=1; further bowl and strike change nothing.
- Six perfect balls with bowl held high → score=36, balls=6, innings_done after the 6th RESULT; strike during RESULT is ignored.
- Assert reset during WINDOW of ball 3 → all outputs 0 next cycle, state IDLE, score is not updated for ball 3.
